// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction/state encodings and reversal helper for the snake controller
package snake_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  // Opposite directions differ only in bit 1 (left<->right, up<->down).
  function automatic logic [1:0] reverse_dir(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

  function automatic logic is_reversal(input logic [1:0] req_dir, input logic [1:0] cur_dir);
    return req_dir == reverse_dir(cur_dir);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, symmetric debounce counter and press-edge pulse for one active-low button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic [CW-1:0] cnt;
  logic          low;

  assign low = ~sync2;

  // The counter only runs while the synchronized level disagrees with the
  // debounced state; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (low == pressed) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt     <= '0;
        pressed <= low;
        press   <= low;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// rtl/snake_move_ctrl.sv - button debounce, reversal filtering, game tick pacing and IDLE/RUN/DEAD control for the snake datapath
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_CYCLES     = 6250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  input  logic       collision,
  output logic       move_tick,
  output logic [1:0] move_direction,
  output logic [1:0] game_state
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICK_CYCLES - 1);

  logic [3:0]    btn_n;
  logic [3:0]    press;
  logic          req_valid;
  logic [1:0]    req_dir;
  logic [1:0]    pending_dir;
  logic [1:0]    cmp_dir;
  logic [TW-1:0] tick_cnt;
  logic          terminal;
  logic          tick_now;
  logic          accept;

  assign btn_n = {btn4, btn3, btn2, btn1};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_n[i]),
      .press (press[i])
    );
  end

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_LEFT;
    if (press[0])      req_dir = DIR_LEFT;
    else if (press[1]) req_dir = DIR_UP;
    else if (press[2]) req_dir = DIR_RIGHT;
    else if (press[3]) req_dir = DIR_DOWN;
    else               req_valid = 1'b0;
  end

  assign terminal = (tick_cnt == TLAST);
  assign tick_now = (game_state == ST_RUN) && terminal && !collision;
  // On a tick the request is judged against the direction being committed now.
  assign cmp_dir  = tick_now ? pending_dir : move_direction;
  assign accept   = req_valid && !is_reversal(req_dir, cmp_dir);

  always_ff @(posedge clk) begin
    if (!reset) begin
      game_state     <= ST_IDLE;
      move_tick      <= 1'b0;
      move_direction <= DIR_RIGHT;
      pending_dir    <= DIR_RIGHT;
      tick_cnt       <= '0;
    end else begin
      move_tick <= 1'b0;
      case (game_state)
        ST_IDLE: begin
          tick_cnt <= '0;
          if (req_valid) begin
            game_state <= ST_RUN;
            if (accept) pending_dir <= req_dir;
          end
        end
        ST_RUN: begin
          if (collision) begin
            game_state <= ST_DEAD;
            tick_cnt   <= '0;
          end else begin
            if (terminal) begin
              tick_cnt       <= '0;
              move_tick      <= 1'b1;
              move_direction <= pending_dir;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
            if (accept) pending_dir <= req_dir;
          end
        end
        ST_DEAD: begin
          tick_cnt <= '0;
          if (req_valid) begin
            game_state     <= ST_IDLE;
            move_direction <= DIR_RIGHT;
            pending_dir    <= DIR_RIGHT;
          end
        end
        default: begin
          game_state <= ST_IDLE;
          tick_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
